// File: rtl/atm_pkg.sv
// Shared definitions for the ATM cash dispenser: denominations, output codes,
// FSM state encoding and the planner's per-cycle verdict.
package atm_pkg;

  localparam int DEN_HI_VAL      = 2000;
  localparam int DEN_MID_VAL     = 500;
  localparam int DEN_LO_VAL      = 100;
  localparam int MAX_AMT_DEFAULT = 20000;

  typedef enum logic [1:0] {
    DEN_NONE = 2'd0,
    DEN_HI   = 2'd1,
    DEN_MID  = 2'd2,
    DEN_LO   = 2'd3
  } note_den_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_AMT = 2'd1,
    ERR_TOO_BIG = 2'd2,
    ERR_SHORT   = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PLAN,
    S_DISPENSE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    PLAN_STEP,
    PLAN_OK,
    PLAN_BAD,
    PLAN_SHORT
  } plan_res_e;

endpackage

// File: rtl/atm_note_planner.sv
// Greedy note planner: one subtraction per step from the remaining amount,
// bounded by cassette inventory; also retires plan entries as notes go out.
module atm_note_planner
  import atm_pkg::*;
#(
  parameter int AMT_W = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             step_i,
  input  note_den_e        take_i,
  input  logic [CNT_W-1:0] cnt_hi_i,
  input  logic [CNT_W-1:0] cnt_mid_i,
  input  logic [CNT_W-1:0] cnt_lo_i,
  output logic [AMT_W-1:0] rem_o,
  output logic [CNT_W-1:0] plan_hi_o,
  output logic [CNT_W-1:0] plan_mid_o,
  output logic [CNT_W-1:0] plan_lo_o,
  output plan_res_e        res_o
);

  localparam logic [AMT_W-1:0] AMT_HI  = AMT_W'(DEN_HI_VAL);
  localparam logic [AMT_W-1:0] AMT_MID = AMT_W'(DEN_MID_VAL);
  localparam logic [AMT_W-1:0] AMT_LO  = AMT_W'(DEN_LO_VAL);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [AMT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] plan_hi_q, plan_hi_d;
  logic [CNT_W-1:0] plan_mid_q, plan_mid_d;
  logic [CNT_W-1:0] plan_lo_q, plan_lo_d;
  note_den_e        sel;

  // Guarded compares keep rem from ever underflowing.
  always_comb begin
    sel   = DEN_NONE;
    res_o = PLAN_STEP;
    if (rem_q >= AMT_HI && plan_hi_q < cnt_hi_i) begin
      sel = DEN_HI;
    end else if (rem_q >= AMT_MID && plan_mid_q < cnt_mid_i) begin
      sel = DEN_MID;
    end else if (rem_q >= AMT_LO && plan_lo_q < cnt_lo_i) begin
      sel = DEN_LO;
    end else if (rem_q == '0) begin
      res_o = PLAN_OK;
    end else if (rem_q < AMT_LO) begin
      res_o = PLAN_BAD;
    end else begin
      res_o = PLAN_SHORT;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rem_d      = rem_q;
    plan_hi_d  = plan_hi_q;
    plan_mid_d = plan_mid_q;
    plan_lo_d  = plan_lo_q;
    if (init_i) begin
      rem_d      = amt_i;
      plan_hi_d  = '0;
      plan_mid_d = '0;
      plan_lo_d  = '0;
    end else if (step_i) begin
      unique case (sel)
        DEN_HI:  begin plan_hi_d  = plan_hi_q + ONE_C;  rem_d = rem_q - AMT_HI;  end
        DEN_MID: begin plan_mid_d = plan_mid_q + ONE_C; rem_d = rem_q - AMT_MID; end
        DEN_LO:  begin plan_lo_d  = plan_lo_q + ONE_C;  rem_d = rem_q - AMT_LO;  end
        default: ;
      endcase
    end else begin
      unique case (take_i)
        DEN_HI:  if (plan_hi_q  != '0) plan_hi_d  = plan_hi_q - ONE_C;
        DEN_MID: if (plan_mid_q != '0) plan_mid_d = plan_mid_q - ONE_C;
        DEN_LO:  if (plan_lo_q  != '0) plan_lo_d  = plan_lo_q - ONE_C;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      plan_hi_q  <= '0;
      plan_mid_q <= '0;
      plan_lo_q  <= '0;
    end else begin
      rem_q      <= rem_d;
      plan_hi_q  <= plan_hi_d;
      plan_mid_q <= plan_mid_d;
      plan_lo_q  <= plan_lo_d;
    end
  end

  assign rem_o      = rem_q;
  assign plan_hi_o  = plan_hi_q;
  assign plan_mid_o = plan_mid_q;
  assign plan_lo_o  = plan_lo_q;

endmodule

// File: rtl/atm_cash_dispenser.sv
// ATM cash dispenser: validates a requested amount, plans notes greedily against
// cassette inventory, then issues them one at a time with a fixed spacing.
module atm_cash_dispenser
  import atm_pkg::*;
#(
  parameter int AMT_W    = 15,
  parameter int CNT_W    = 8,
  parameter int NOTE_GAP = 4,
  parameter int MAX_AMT  = MAX_AMT_DEFAULT,
  parameter int INIT_CNT = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             load,
  input  logic [CNT_W-1:0] load_hi,
  input  logic [CNT_W-1:0] load_mid,
  input  logic [CNT_W-1:0] load_lo,
  output logic             note_vld,
  output logic [1:0]       note_den,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cnt_hi,
  output logic [CNT_W-1:0] cnt_mid,
  output logic [CNT_W-1:0] cnt_lo
);

  localparam int               GAP_W   = (NOTE_GAP > 2) ? $clog2(NOTE_GAP - 1) : 1;
  localparam logic [GAP_W-1:0] GAP_RLD = GAP_W'(NOTE_GAP - 2);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_C  = CNT_W'(INIT_CNT);
  localparam logic [AMT_W-1:0] MAX_A   = AMT_W'(MAX_AMT);

  state_e           state_q, state_d;
  err_code_e        err_code_q, err_code_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_hi_q, cnt_hi_d, cnt_mid_q, cnt_mid_d, cnt_lo_q, cnt_lo_d;

  logic             plan_init, plan_step;
  note_den_e        take, den;
  logic             last_note;
  logic [AMT_W-1:0] rem;
  logic [CNT_W-1:0] plan_hi, plan_mid, plan_lo;
  plan_res_e        plan_res;

  atm_note_planner #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_planner (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_i    (plan_init),
    .amt_i     (amt),
    .step_i    (plan_step),
    .take_i    (take),
    .cnt_hi_i  (cnt_hi_q),
    .cnt_mid_i (cnt_mid_q),
    .cnt_lo_i  (cnt_lo_q),
    .rem_o     (rem),
    .plan_hi_o (plan_hi),
    .plan_mid_o(plan_mid),
    .plan_lo_o (plan_lo),
    .res_o     (plan_res)
  );

  // Highest outstanding denomination goes first; last_note flags the final one.
  always_comb begin
    den = DEN_LO;
    if (plan_hi != '0)       den = DEN_HI;
    else if (plan_mid != '0) den = DEN_MID;
    last_note = (den == DEN_HI  && plan_hi  == ONE_C && plan_mid == '0 && plan_lo == '0) ||
                (den == DEN_MID && plan_mid == ONE_C && plan_lo == '0) ||
                (den == DEN_LO  && plan_lo  == ONE_C);
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    gap_d      = gap_q;
    cnt_hi_d   = cnt_hi_q;
    cnt_mid_d  = cnt_mid_q;
    cnt_lo_d   = cnt_lo_q;
    plan_init  = 1'b0;
    plan_step  = 1'b0;
    take       = DEN_NONE;
    note_vld   = 1'b0;
    note_den   = DEN_NONE;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          cnt_hi_d  = load_hi;
          cnt_mid_d = load_mid;
          cnt_lo_d  = load_lo;
        end else if (start) begin
          plan_init  = 1'b1;
          err_code_d = ERR_NONE;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rem == '0) begin
          err_code_d = ERR_BAD_AMT;
          state_d    = S_ERR;
        end else if (rem >= MAX_A) begin
          err_code_d = ERR_TOO_BIG;
          state_d    = S_ERR;
        end else begin
          state_d = S_PLAN;
        end
      end
      S_PLAN: begin
        plan_step = 1'b1;
        unique case (plan_res)
          PLAN_OK:    state_d = S_DISPENSE;
          PLAN_BAD:   begin err_code_d = ERR_BAD_AMT; state_d = S_ERR; end
          PLAN_SHORT: begin err_code_d = ERR_SHORT;   state_d = S_ERR; end
          default:    ;
        endcase
      end
      S_DISPENSE: begin
        note_vld = 1'b1;
        note_den = den;
        take     = den;
        unique case (den)
          DEN_HI:  if (cnt_hi_q  != '0) cnt_hi_d  = cnt_hi_q - ONE_C;
          DEN_MID: if (cnt_mid_q != '0) cnt_mid_d = cnt_mid_q - ONE_C;
          default: if (cnt_lo_q  != '0) cnt_lo_d  = cnt_lo_q - ONE_C;
        endcase
        gap_d   = GAP_RLD;
        state_d = last_note ? S_DONE : S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_DISPENSE;
        else             gap_d   = gap_q - GAP_ONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      err_code_q <= ERR_NONE;
      gap_q      <= '0;
      cnt_hi_q   <= INIT_C;
      cnt_mid_q  <= INIT_C;
      cnt_lo_q   <= INIT_C;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      gap_q      <= gap_d;
      cnt_hi_q   <= cnt_hi_d;
      cnt_mid_q  <= cnt_mid_d;
      cnt_lo_q   <= cnt_lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign err_code = err_code_q;
  assign cnt_hi   = cnt_hi_q;
  assign cnt_mid  = cnt_mid_q;
  assign cnt_lo   = cnt_lo_q;

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Scoreboard bench for atm_cash_dispenser: expected notes are queued when a
// request is launched and popped by a monitor as note_vld pulses appear.
module tb_atm_cash_dispenser;

  localparam int AMT_W    = 15;
  localparam int CNT_W    = 8;
  localparam int NOTE_GAP = 4;
  localparam int MAX_AMT  = 20000;
  localparam int INIT_CNT = 50;
  localparam int TIMEOUT  = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AMT_W-1:0] amt = '0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] load_hi = '0, load_mid = '0, load_lo = '0;
  logic             note_vld, busy, done, err;
  logic [1:0]       note_den, err_code;
  logic [CNT_W-1:0] cnt_hi, cnt_mid, cnt_lo;

  atm_cash_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .NOTE_GAP(NOTE_GAP), .MAX_AMT(MAX_AMT), .INIT_CNT(INIT_CNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amt(amt), .load(load),
    .load_hi(load_hi), .load_mid(load_mid), .load_lo(load_lo),
    .note_vld(note_vld), .note_den(note_den), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .cnt_hi(cnt_hi), .cnt_mid(cnt_mid), .cnt_lo(cnt_lo)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [1:0] exp_q[$];
  int notes_seen, done_seen, err_seen, prev_note, first_note;
  int start_cyc;
  int m_hi = INIT_CNT, m_mid = INIT_CNT, m_lo = INIT_CNT;
  int e_code, e_hi, e_mid, e_lo;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every note and checks the spacing.
  always @(negedge clk) begin
    logic [1:0] e;
    if (note_vld === 1'b1) begin
      notes_seen++;
      if (notes_seen == 1) first_note = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL note_unexpected: got den=%0d, none expected", note_den);
      end else begin
        e = exp_q.pop_front();
        if (note_den !== e) begin
          n_fail++;
          $display("FAIL note_den: got %0d, expected %0d", note_den, e);
        end
      end
      if (prev_note >= 0) begin
        n_tests++;
        if (cyc - prev_note != NOTE_GAP) begin
          n_fail++;
          $display("FAIL note_gap: got %0d cycles, expected %0d", cyc - prev_note, NOTE_GAP);
        end
      end
      prev_note = cyc;
    end
    if (done === 1'b1) done_seen++;
    if (err === 1'b1)  err_seen++;
  end

  task automatic model(input int a, output int code, output int nh, output int nm, output int nl);
    int r;
    nh = 0; nm = 0; nl = 0; code = 0; r = a;
    if (a == 0) code = 1;
    else if (a >= MAX_AMT) code = 2;
    else begin
      while (r >= 2000 && nh < m_hi) begin r -= 2000; nh++; end
      while (r >= 500 && nm < m_mid) begin r -= 500; nm++; end
      while (r >= 100 && nl < m_lo) begin r -= 100; nl++; end
      if (r != 0) code = (r < 100) ? 1 : 3;
    end
  endtask

  task automatic launch(input int a);
    model(a, e_code, e_hi, e_mid, e_lo);
    if (e_code == 0) begin
      repeat (e_hi)  exp_q.push_back(2'd1);
      repeat (e_mid) exp_q.push_back(2'd2);
      repeat (e_lo)  exp_q.push_back(2'd3);
    end
    notes_seen = 0; done_seen = 0; err_seen = 0; prev_note = -1; first_note = -1;
    @(negedge clk);
    start = 1'b1; amt = AMT_W'(a); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_txn(input string name);
    int waited = 0;
    while (done !== 1'b1 && err !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (waited >= TIMEOUT) begin
      n_fail++;
      $display("FAIL %s timeout: no done/err within %0d cycles", name, TIMEOUT);
    end
    if (e_code == 0) begin
      m_hi -= e_hi; m_mid -= e_mid; m_lo -= e_lo;
      n_tests++;
      if (done_seen != 1 || err_seen != 0) begin
        n_fail++;
        $display("FAIL %s pulses: done=%0d err=%0d, expected 1/0", name, done_seen, err_seen);
      end
      n_tests++;
      if (notes_seen != e_hi + e_mid + e_lo || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL %s notes: got %0d, expected %0d", name, notes_seen, e_hi + e_mid + e_lo);
      end
      n_tests++;
      if (first_note - start_cyc != 3 + e_hi + e_mid + e_lo) begin
        n_fail++;
        $display("FAIL %s latency: got %0d, expected %0d", name, first_note - start_cyc,
                 3 + e_hi + e_mid + e_lo);
      end
    end else begin
      n_tests++;
      if (err_seen != 1 || done_seen != 0 || notes_seen != 0) begin
        n_fail++;
        $display("FAIL %s pulses: err=%0d done=%0d notes=%0d, expected 1/0/0", name, err_seen,
                 done_seen, notes_seen);
      end
      n_tests++;
      if (err_code !== 2'(e_code)) begin
        n_fail++;
        $display("FAIL %s err_code: got %0d, expected %0d", name, err_code, e_code);
      end
    end
    n_tests++;
    if (cnt_hi !== CNT_W'(m_hi) || cnt_mid !== CNT_W'(m_mid) || cnt_lo !== CNT_W'(m_lo) ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cnt/busy: got %0d/%0d/%0d busy=%0b, expected %0d/%0d/%0d busy=0", name,
               cnt_hi, cnt_mid, cnt_lo, busy, m_hi, m_mid, m_lo);
    end
  endtask

  task automatic do_load(input int h, input int m, input int l);
    @(negedge clk);
    load = 1'b1; load_hi = CNT_W'(h); load_mid = CNT_W'(m); load_lo = CNT_W'(l);
    @(negedge clk);
    load = 1'b0;
    m_hi = h; m_mid = m; m_lo = l;
  endtask

  task automatic wait_first_note(input string name);
    int waited = 0;
    while (notes_seen < 1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (notes_seen < 1) begin
      n_fail++;
      $display("FAIL %s first_note: none within %0d cycles", name, TIMEOUT);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (note_vld !== 1'b0 || note_den !== 2'd0 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: vld=%0b den=%0d busy=%0b done=%0b err=%0b code=%0d, expected all 0",
               note_vld, note_den, busy, done, err, err_code);
    end
    n_tests++;
    if (cnt_hi !== 8'd50 || cnt_mid !== 8'd50 || cnt_lo !== 8'd50) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d, expected 50/50/50", cnt_hi, cnt_mid, cnt_lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    launch(2600);
    finish_txn("basic_2600");
    n_tests++;
    if (cnt_hi !== 8'd49 || cnt_mid !== 8'd49 || cnt_lo !== 8'd49) begin
      n_fail++;
      $display("FAIL basic_cnt: got %0d/%0d/%0d, expected 49/49/49", cnt_hi, cnt_mid, cnt_lo);
    end
  endtask

  task automatic test_errors();
    launch(150);   finish_txn("err_150");
    launch(0);     finish_txn("err_0");
    launch(20000); finish_txn("err_20000");
    n_tests++;
    if (err_code !== 2'd2 || cnt_hi !== 8'd49 || cnt_mid !== 8'd49 || cnt_lo !== 8'd49) begin
      n_fail++;
      $display("FAIL err_state: code=%0d cnt=%0d/%0d/%0d, expected 2 and 49/49/49", err_code,
               cnt_hi, cnt_mid, cnt_lo);
    end
    launch(19900); finish_txn("max_minus_100");
  endtask

  task automatic test_low_inventory();
    do_load(0, 1, 2);
    launch(700);
    finish_txn("load_700");
    n_tests++;
    if (cnt_hi !== 8'd0 || cnt_mid !== 8'd0 || cnt_lo !== 8'd0) begin
      n_fail++;
      $display("FAIL empty_cnt: got %0d/%0d/%0d, expected 0/0/0", cnt_hi, cnt_mid, cnt_lo);
    end
    do_load(0, 1, 0);
    launch(600);
    finish_txn("greedy_short_600");
    n_tests++;
    if (err_code !== 2'd3 || cnt_mid !== 8'd1) begin
      n_fail++;
      $display("FAIL short_state: code=%0d cnt_mid=%0d, expected 3 and 1", err_code, cnt_mid);
    end
  endtask

  task automatic test_start_during_gap();
    do_load(50, 50, 50);
    launch(4100);
    wait_first_note("gap_4100");
    @(negedge clk);
    start = 1'b1; amt = AMT_W'(2600);
    load = 1'b1; load_hi = 8'd7; load_mid = 8'd7; load_lo = 8'd7;
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    finish_txn("gap_4100");
    n_tests++;
    if (notes_seen != 3 || done_seen != 1 || cnt_hi !== 8'd48 || cnt_mid !== 8'd50 ||
        cnt_lo !== 8'd49) begin
      n_fail++;
      $display("FAIL gap_ignore: notes=%0d done=%0d cnt=%0d/%0d/%0d, expected 3 1 48/50/49",
               notes_seen, done_seen, cnt_hi, cnt_mid, cnt_lo);
    end
  endtask

  task automatic test_reset_mid();
    launch(2600);
    wait_first_note("reset_mid");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (note_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        cnt_hi !== 8'd50 || cnt_mid !== 8'd50 || cnt_lo !== 8'd50) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: vld=%0b busy=%0b cnt=%0d/%0d/%0d, expected 0 0 50/50/50",
               note_vld, busy, cnt_hi, cnt_mid, cnt_lo);
    end
    rst_n = 1'b1;
    exp_q.delete();
    m_hi = INIT_CNT; m_mid = INIT_CNT; m_lo = INIT_CNT;
    repeat (40) @(negedge clk);
    n_tests++;
    if (notes_seen != 1 || busy !== 1'b0 || done_seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_after: notes=%0d busy=%0b done=%0d, expected 1 0 0", notes_seen,
               busy, done_seen);
    end
  endtask

  task automatic test_load_and_start();
    bit busy_hit = 1'b0;
    notes_seen = 0;
    @(negedge clk);
    load = 1'b1; start = 1'b1; amt = AMT_W'(2600);
    load_hi = 8'd10; load_mid = 8'd20; load_lo = 8'd30;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0) busy_hit = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (busy_hit || notes_seen != 0 || cnt_hi !== 8'd10 || cnt_mid !== 8'd20 ||
        cnt_lo !== 8'd30) begin
      n_fail++;
      $display("FAIL load_wins: busy_seen=%0b notes=%0d cnt=%0d/%0d/%0d, expected 0 0 10/20/30",
               busy_hit, notes_seen, cnt_hi, cnt_mid, cnt_lo);
    end
  endtask

  initial begin
    notes_seen = 0; done_seen = 0; err_seen = 0; prev_note = -1; first_note = -1;
    test_reset();
    test_basic();
    test_errors();
    test_low_inventory();
    test_start_during_gap();
    test_reset_mid();
    test_load_and_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
